// File: rtl/control_fsm.sv
// Control sequencer for a simple multi-cycle processor: fetch (T0) and up to
// three execute steps (T1..T3) that drive register enables, bus selects and the
// ALU operation from the current state and the instruction word.
module control_fsm (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Run,
    input  logic [15:0] IR,
    input  logic        Gnz,
    output logic [7:0]  Rin,
    output logic [7:0]  Rout,
    output logic        IRin,
    output logic        Ain,
    output logic        Gin,
    output logic        Gout,
    output logic        DINout,
    output logic        AddSub,
    output logic        PCinc,
    output logic        Done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    state_t     state;
    state_t     next_state;
    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] rx_sel;
    logic [7:0] ry_sel;
    logic       unused_ir;

    assign opcode    = IR[15:13];
    assign rx        = IR[12:10];
    assign ry        = IR[9:7];
    assign rx_sel    = 8'b0000_0001 << rx;
    assign ry_sel    = 8'b0000_0001 << ry;
    assign unused_ir = ^IR[6:0];

    // State register; reset always returns to fetch and wins over Run.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= T0;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode; outputs held low while reset is asserted
    // so an aborted instruction cannot emit any further enables.
    always_comb begin
        next_state = state;
        Rin        = 8'h00;
        Rout       = 8'h00;
        IRin       = 1'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        Gout       = 1'b0;
        DINout     = 1'b0;
        AddSub     = 1'b0;
        PCinc      = 1'b0;
        Done       = 1'b0;

        case (state)
            T0: begin
                if (Run) begin
                    IRin       = 1'b1;
                    PCinc      = 1'b1;
                    next_state = T1;
                end
            end
            T1: begin
                next_state = T0;
                case (opcode)
                    OP_MV: begin
                        Rout = ry_sel;
                        Rin  = rx_sel;
                        Done = 1'b1;
                    end
                    OP_MVI: begin
                        DINout = 1'b1;
                        Rin    = rx_sel;
                        PCinc  = 1'b1;
                        Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout       = rx_sel;
                        Ain        = 1'b1;
                        next_state = T2;
                    end
                    OP_MVNZ: begin
                        if (Gnz) begin
                            Rout = ry_sel;
                            Rin  = rx_sel;
                        end
                        Done = 1'b1;
                    end
                    default: begin
                        Done = 1'b1;
                    end
                endcase
            end
            T2: begin
                Rout       = ry_sel;
                Gin        = 1'b1;
                AddSub     = (opcode == OP_SUB);
                next_state = T3;
            end
            T3: begin
                Gout       = 1'b1;
                Rin        = rx_sel;
                Done       = 1'b1;
                next_state = T0;
            end
            default: begin
                next_state = T0;
            end
        endcase

        if (!Resetn) begin
            Rin    = 8'h00;
            Rout   = 8'h00;
            IRin   = 1'b0;
            Ain    = 1'b0;
            Gin    = 1'b0;
            Gout   = 1'b0;
            DINout = 1'b0;
            AddSub = 1'b0;
            PCinc  = 1'b0;
            Done   = 1'b0;
        end
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- Clock  in  1  single system clock; all state changes on its rising edge.
- Resetn  in  1  synchronous, active-low reset.
- Run  in  1  start request; sampled only in T0.
- IR  in  16  instruction word from the instruction register.
- Gnz  in  1  1 when the G (ALU result) register is non-zero.
- Rin  out  8  one-hot register load enables; Rin[7] loads the PC.
- Rout  out  8  one-hot register-to-bus select.
- IRin  out  1  instruction register load enable.
- Ain  out  1  A operand register load enable.
- Gin  out  1  G register load enable.
- Gout  out  1  G-to-bus select.
- DINout  out  1  DIN-to-bus select.
- AddSub  out  1  ALU operation: 0 = add, 1 = subtract.
- PCinc  out  1  PC increment request.
- Done  out  1  instruction-complete pulse.

REQ-002 The block SHALL use one clock, Clock; reset SHALL be synchronous and active-low on Resetn.
REQ-003 The block SHALL decode IR as follows: opcode = IR[15:13], Rx = IR[12:10], Ry = IR[9:7]; IR[6:0] is ignored.

Function
REQ-004 The block SHALL implement a state register with the states T0 (fetch), T1, T2 and T3.
REQ-005 Outputs SHALL be combinational functions of the current state and IR; any output not listed for a state/opcode SHALL be 0.
REQ-006 In T0 with Run=1, the block SHALL assert IRin and PCinc and go to T1; in T0 with Run=0, all outputs SHALL be 0 and the state SHALL stay T0.
REQ-007 Run SHALL be ignored in T1, T2 and T3.
REQ-008 In T1 for opcode 000 (mv), the block SHALL assert Rout[Ry], Rin[Rx] and Done, then go to T0.
REQ-009 In T1 for opcode 001 (mvi), the block SHALL assert DINout, Rin[Rx], PCinc and Done, then go to T0.
REQ-010 In T1 for opcode 010 (add) or 011 (sub), the block SHALL assert Rout[Rx] and Ain, then go to T2.
REQ-011 In T2, the block SHALL assert Rout[Ry] and Gin, with AddSub = 1 for opcode 011 and 0 otherwise, then go to T3.
REQ-012 In T3, the block SHALL assert Gout, Rin[Rx] and Done, then go to T0.
REQ-013 In T1 for opcode 100 (mvnz):
- if Gnz=1, the block SHALL assert Rout[Ry] and Rin[Rx];
- in either case it SHALL assert Done and go to T0.
REQ-014 In T1 for opcodes 101-111 (reserved), the block SHALL assert only Done and go to T0 (NOP).
REQ-015 At most one of Rout[*], Gout or DINout SHALL be 1 in any cycle.
REQ-016 At most one Rin bit SHALL be 1 in any cycle.
REQ-017 Done SHALL be 1 for exactly one cycle per instruction; Done=1 SHALL always be followed by state T0.
REQ-018 Instruction latency from the T0 fetch cycle SHALL be:
- mv, mvi, mvnz, NOP: 2 cycles;
- add, sub: 4 cycles.
REQ-019 When Rx=Ry, operation SHALL be unchanged; for add R1,R1 the sequence is Rout[1]+Ain, then Rout[1]+Gin.
REQ-020 Writing Rx=7 SHALL assert Rin[7] normally; when Rin[7] and PCinc coincide (mvi R7), the PC register gives load priority, and the FSM does not suppress either signal.
REQ-021 Back-to-back instructions SHALL be supported: with Run held at 1, T0 SHALL follow Done with no idle cycle.

Reset
REQ-022 When Resetn=0 at a rising edge of Clock, the state SHALL become T0 regardless of the current state.
REQ-023 While in reset and in the first T0 cycle after reset with Run=0, all outputs SHALL be 0.
REQ-024 A reset during T1, T2 or T3 SHALL abort the instruction: no Done, no further Rin, Gin or Ain pulses from that instruction.
REQ-025 Resetn SHALL take priority over Run in the same cycle.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- IR=0x0500 (mv R1,R2), Run=1 -> T0: IRin=1, PCinc=1; T1: Rout=0x04, Rin=0x02, Done=1.
- IR=0x4E00 (add R3,R4) -> T1: Rout=0x08, Ain=1; T2: Rout=0x10, Gin=1, AddSub=0; T3: Gout=1, Rin=0x08, Done=1.
- IR=0x6080 (sub R0,R1) -> T2: AddSub=1, Rout=0x02; T3: Rin=0x01, Done=1.
- IR=0x3400 (mvi R5) -> T1: DINout=1, Rin=0x20, PCinc=1, Done=1.
- IR=0x9880 (mvnz R6,R1):
  - with Gnz=0 -> T1: Rin=0x00, Rout=0x00, Done=1;
  - with Gnz=1 -> T1: Rout=0x02, Rin=0x40, Done=1.
- add in progress, Resetn=0 during T2 -> next cycle T0, all outputs 0, no Done; then Run=1 with IR=0xE000 (NOP) -> Done in T1 only.
